// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing and entry layout, also used by the reservation station
// and the execution unit.
package rob_pkg;

  localparam int DEPTH  = 32;
  localparam int IDX_W  = 5;
  localparam int DATA_W = 16;
  localparam int REG_W  = 5;
  localparam int PTR_W  = IDX_W + 1;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              no_wb;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  // Entry index of a wrap-bit pointer
  function automatic logic [IDX_W-1:0] ptr_idx(input logic [PTR_W-1:0] ptr);
    return ptr[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rob_fwd_lookup.sv
// Dual read port over the ROB entry array, so the reservation station can pick up
// completed-but-uncommitted operands. Instantiated only when ROB_FWD_EN is defined.
module rob_fwd_lookup
  import rob_pkg::*;
(
  input  rob_entry_t        entries [DEPTH],
  input  logic [IDX_W-1:0]  tag_a,
  input  logic [IDX_W-1:0]  tag_b,
  output logic              ready_a,
  output logic [DATA_W-1:0] data_a,
  output logic              ready_b,
  output logic [DATA_W-1:0] data_b
);

  // Registered entry state only, so a writeback in this same cycle is not yet visible
  always_comb begin
    ready_a = entries[tag_a].busy & entries[tag_a].done;
    data_a  = entries[tag_a].data;
    ready_b = entries[tag_b].busy & entries[tag_b].done;
    data_b  = entries[tag_b].data;
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocate/retire, out-of-order writeback, tail squash on flush.
// Define ROB_FWD_EN to add the lookup_* operand forwarding ports.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic              alloc_no_wb,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_tag,
  input  logic              rob_write_en,
  input  logic [IDX_W-1:0]  rob_entry,
  input  logic [DATA_W-1:0] rob_write_data,
  input  logic              flush,
  input  logic [IDX_W-1:0]  flush_tag,
`ifdef ROB_FWD_EN
  input  logic [IDX_W-1:0]  lookup_tag_a,
  input  logic [IDX_W-1:0]  lookup_tag_b,
  output logic              lookup_ready_a,
  output logic              lookup_ready_b,
  output logic [DATA_W-1:0] lookup_data_a,
  output logic [DATA_W-1:0] lookup_data_b,
`endif
  output logic              commit_valid,
  output logic [IDX_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic              commit_wr_en,
  output logic [IDX_W:0]    count,
  output logic              empty,
  output logic              full
);

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] head_nxt_s;
  logic [PTR_W-1:0] tail_nxt_s;
  rob_entry_t       entry_r     [DEPTH];
  rob_entry_t       entry_nxt_s [DEPTH];
  rob_entry_t       head_entry_s;
  logic             empty_s;
  logic             full_s;
  logic             alloc_fire_s;
  logic             commit_fire_s;
  logic             flush_hit_s;
  logic [IDX_W-1:0] flush_dist_s;
  logic [PTR_W-1:0] flush_tail_s;
  logic [PTR_W-1:0] squash_cnt_s;

  // Occupancy, handshakes and flush geometry, all from registered state
  always_comb begin
    empty_s       = (head_r == tail_r);
    full_s        = (ptr_idx(head_r) == ptr_idx(tail_r)) && (head_r[IDX_W] != tail_r[IDX_W]);
    head_entry_s  = entry_r[ptr_idx(head_r)];
    alloc_fire_s  = alloc_valid & ~full_s & ~flush;
    commit_fire_s = head_entry_s.busy & head_entry_s.done;
    flush_hit_s   = flush & entry_r[flush_tag].busy;
    // New tail keeps the wrap bit consistent by walking forward from head
    flush_dist_s  = flush_tag - ptr_idx(head_r);
    flush_tail_s  = head_r + {1'b0, flush_dist_s} + PTR_W'(1'b1);
    squash_cnt_s  = tail_r - flush_tail_s;
  end

  assign alloc_ready = ~full_s & ~flush;
  assign alloc_tag   = ptr_idx(tail_r);
  assign count       = tail_r - head_r;
  assign empty       = empty_s;
  assign full        = full_s;

  // Pointer advance; flush outranks allocation
  always_comb begin
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    if (commit_fire_s) begin
      head_nxt_s = head_r + PTR_W'(1'b1);
    end else begin
      head_nxt_s = head_r;
    end
    if (flush_hit_s) begin
      tail_nxt_s = flush_tail_s;
    end else if (alloc_fire_s) begin
      tail_nxt_s = tail_r + PTR_W'(1'b1);
    end else begin
      tail_nxt_s = tail_r;
    end
  end

  // Per-entry update: free/squash beats alloc beats writeback
  always_comb begin
    logic [IDX_W-1:0] off_v;
    off_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_v = IDX_W'(i) - flush_tag - IDX_W'(1'b1);
      if ((commit_fire_s && (ptr_idx(head_r) == IDX_W'(i))) ||
          (flush_hit_s && ({1'b0, off_v} < squash_cnt_s))) begin
        entry_nxt_s[i] = '0;
      end else if (alloc_fire_s && (ptr_idx(tail_r) == IDX_W'(i))) begin
        entry_nxt_s[i]       = entry_r[i];
        entry_nxt_s[i].busy  = 1'b1;
        entry_nxt_s[i].done  = 1'b0;
        entry_nxt_s[i].no_wb = alloc_no_wb;
        entry_nxt_s[i].dest  = alloc_dest;
      end else if (rob_write_en && (rob_entry == IDX_W'(i)) && entry_r[i].busy) begin
        entry_nxt_s[i]      = entry_r[i];
        entry_nxt_s[i].done = 1'b1;
        entry_nxt_s[i].data = rob_write_data;
      end else begin
        entry_nxt_s[i] = entry_r[i];
      end
    end
  end

  // Pointer and entry array state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r <= '0;
      tail_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= entry_nxt_s[i];
      end
    end
  end

  // Registered retire port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_dest  <= '0;
      commit_data  <= '0;
      commit_wr_en <= 1'b0;
    end else if (commit_fire_s) begin
      commit_valid <= 1'b1;
      commit_tag   <= ptr_idx(head_r);
      commit_dest  <= head_entry_s.dest;
      commit_data  <= head_entry_s.data;
      commit_wr_en <= ~head_entry_s.no_wb;
    end else begin
      commit_valid <= 1'b0;
      commit_wr_en <= 1'b0;
    end
  end

`ifdef ROB_FWD_EN
  rob_fwd_lookup u_fwd_lookup (
    .entries (entry_r),
    .tag_a   (lookup_tag_a),
    .tag_b   (lookup_tag_b),
    .ready_a (lookup_ready_a),
    .data_a  (lookup_data_a),
    .ready_b (lookup_ready_b),
    .data_b  (lookup_data_b)
  );
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (forwarding checks only under ROB_FWD_EN).
module tb_reorder_buffer;
  import rob_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_no_wb;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_tag;
  logic              rob_write_en;
  logic [IDX_W-1:0]  rob_entry;
  logic [DATA_W-1:0] rob_write_data;
  logic              flush;
  logic [IDX_W-1:0]  flush_tag;
  logic              commit_valid;
  logic [IDX_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic              commit_wr_en;
  logic [IDX_W:0]    count;
  logic              empty;
  logic              full;
`ifdef ROB_FWD_EN
  logic [IDX_W-1:0]  lookup_tag_a;
  logic [IDX_W-1:0]  lookup_tag_b;
  logic              lookup_ready_a;
  logic              lookup_ready_b;
  logic [DATA_W-1:0] lookup_data_a;
  logic [DATA_W-1:0] lookup_data_b;
`endif

  int check_cnt = 0;
  int fail_cnt  = 0;

  reorder_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_dest     (alloc_dest),
    .alloc_no_wb    (alloc_no_wb),
    .alloc_ready    (alloc_ready),
    .alloc_tag      (alloc_tag),
    .rob_write_en   (rob_write_en),
    .rob_entry      (rob_entry),
    .rob_write_data (rob_write_data),
    .flush          (flush),
    .flush_tag      (flush_tag),
`ifdef ROB_FWD_EN
    .lookup_tag_a   (lookup_tag_a),
    .lookup_tag_b   (lookup_tag_b),
    .lookup_ready_a (lookup_ready_a),
    .lookup_ready_b (lookup_ready_b),
    .lookup_data_a  (lookup_data_a),
    .lookup_data_b  (lookup_data_b),
`endif
    .commit_valid   (commit_valid),
    .commit_tag     (commit_tag),
    .commit_dest    (commit_dest),
    .commit_data    (commit_data),
    .commit_wr_en   (commit_wr_en),
    .count          (count),
    .empty          (empty),
    .full           (full)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input int tag, input logic [DATA_W-1:0] val);
    rob_write_en   = 1'b1;
    rob_entry      = IDX_W'(tag);
    rob_write_data = val;
  endtask

  task automatic wb_off();
    rob_write_en = 1'b0;
  endtask

  task automatic expect_commit(input string tag, input int t, input int d, input int v, input int wr);
    check_value({tag, "_valid"}, 32'(commit_valid), 32'd1);
    check_value({tag, "_tag"},   32'(commit_tag),   32'(t));
    check_value({tag, "_dest"},  32'(commit_dest),  32'(d));
    check_value({tag, "_data"},  32'(commit_data),  32'(v));
    check_value({tag, "_wr_en"}, 32'(commit_wr_en), 32'(wr));
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    alloc_valid    = 1'b0;
    alloc_dest     = '0;
    alloc_no_wb    = 1'b0;
    rob_write_en   = 1'b0;
    rob_entry      = '0;
    rob_write_data = '0;
    flush          = 1'b0;
    flush_tag      = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic alloc_one(input int dest, input logic no_wb);
    alloc_valid = 1'b1;
    alloc_dest  = REG_W'(dest);
    alloc_no_wb = no_wb;
    tick();
    alloc_valid = 1'b0;
    alloc_no_wb = 1'b0;
  endtask

  initial begin
`ifdef ROB_FWD_EN
    lookup_tag_a = '0;
    lookup_tag_b = '0;
`endif
    // 1: reset state and first allocations
    reset = 1'b0;
    alloc_valid = 1'b0; alloc_dest = '0; alloc_no_wb = 1'b0;
    rob_write_en = 1'b0; rob_entry = '0; rob_write_data = '0;
    flush = 1'b0; flush_tag = '0;
    tick();
    check_value("rst_count", 32'(count), 32'd0);
    check_value("rst_empty", 32'(empty), 32'd1);
    check_value("rst_full", 32'(full), 32'd0);
    check_value("rst_commit_valid", 32'(commit_valid), 32'd0);
    check_value("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check_value("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_value("t1_alloc_tag", 32'(alloc_tag), 32'(i));
      alloc_one(3 + i, 1'b0);
    end
    check_value("t1_count", 32'(count), 32'd3);
    check_value("t1_empty", 32'(empty), 32'd0);

    // 2: out-of-order writeback, in-order commit, two-edge latency
    wb(2, 16'h0030); tick(); wb_off();
    check_value("t2_no_commit_tag2", 32'(commit_valid), 32'd0);
    wb(0, 16'h0010); tick(); wb_off();
    check_value("t2_lat_edge1", 32'(commit_valid), 32'd0);
    tick();
    expect_commit("t2_c0", 0, 3, 16'h0010, 1);
    wb(1, 16'h0020); tick(); wb_off();
    check_value("t2_no_commit_gap", 32'(commit_valid), 32'd0);
    tick();
    expect_commit("t2_c1", 1, 4, 16'h0020, 1);
    tick();
    expect_commit("t2_c2", 2, 5, 16'h0030, 1);
    tick();
    check_value("t2_idle", 32'(commit_valid), 32'd0);
    check_value("t2_count", 32'(count), 32'd0);
    check_value("t2_empty", 32'(empty), 32'd1);

    // 3: fill to full (head/tail at 3), ignored 33rd alloc, refill on freeing cycle+1
    alloc_valid = 1'b1;
    alloc_no_wb = 1'b0;
    for (int i = 0; i < 32; i++) begin
      alloc_dest = REG_W'(i);
      tick();
    end
    check_value("t3_full", 32'(full), 32'd1);
    check_value("t3_count", 32'(count), 32'd32);
    check_value("t3_alloc_ready", 32'(alloc_ready), 32'd0);
    check_value("t3_alloc_tag", 32'(alloc_tag), 32'd3);
    alloc_dest = REG_W'(30);
    tick();
    check_value("t3_ignored_count", 32'(count), 32'd32);
    check_value("t3_ignored_tag", 32'(alloc_tag), 32'd3);
    wb(3, 16'h0033); tick(); wb_off();
    check_value("t3_wb_count", 32'(count), 32'd32);
    check_value("t3_wb_full", 32'(full), 32'd1);
    tick();
    expect_commit("t3_c3", 3, 0, 16'h0033, 1);
    check_value("t3_free_full", 32'(full), 32'd0);
    check_value("t3_free_count", 32'(count), 32'd31);
    check_value("t3_free_ready", 32'(alloc_ready), 32'd1);
    tick();
    alloc_valid = 1'b0;
    check_value("t3_refill_count", 32'(count), 32'd32);
    check_value("t3_refill_full", 32'(full), 32'd1);

    // 6a: asynchronous reset with live entries and a commit pulse showing
    wb(4, 16'h0044); tick(); wb_off(); tick();
    check_value("t6_pre_commit_valid", 32'(commit_valid), 32'd1);
    check_value("t6_pre_count", 32'(count), 32'd31);
    reset = 1'b0;
    #1;
    check_value("t6_async_count", 32'(count), 32'd0);
    check_value("t6_async_commit_valid", 32'(commit_valid), 32'd0);
    check_value("t6_async_empty", 32'(empty), 32'd1);
    check_value("t6_async_full", 32'(full), 32'd0);
    tick();
    reset = 1'b1;
    #1;

    // 4: 40 single-entry rounds, tag wrap, no_wb entry, stale writeback
    for (int i = 0; i < 40; i++) begin
      check_value("t4_alloc_tag", 32'(alloc_tag), 32'(i % 32));
      alloc_one(i % 32, (i == 7) ? 1'b1 : 1'b0);
      wb(i % 32, DATA_W'(16'h0100 + i)); tick(); wb_off();
      tick();
      expect_commit("t4_round", i % 32, i % 32, 16'h0100 + i, (i == 7) ? 0 : 1);
    end
    wb(8, 16'hDEAD); tick(); wb_off();
    check_value("t4_stale_count", 32'(count), 32'd0);
    check_value("t4_tag41", 32'(alloc_tag), 32'd8);
    alloc_one(9, 1'b0);
    tick(); tick();
    check_value("t4_realloc_not_done", 32'(commit_valid), 32'd0);
    wb(8, 16'h0028); tick(); wb_off(); tick();
    expect_commit("t4_c41", 8, 9, 16'h0028, 1);

    // 5: flush squashes younger entries; same-cycle writeback dropped
    do_reset();
    for (int i = 0; i < 6; i++) alloc_one(10 + i, 1'b0);
    check_value("t5_pre_count", 32'(count), 32'd6);
    flush = 1'b1;
    flush_tag = IDX_W'(2);
    alloc_valid = 1'b1;
    alloc_dest = REG_W'(31);
    wb(4, 16'h4444);
    #1;
    check_value("t5_flush_ready", 32'(alloc_ready), 32'd0);
    tick();
    flush = 1'b0; alloc_valid = 1'b0; wb_off();
    check_value("t5_flush_count", 32'(count), 32'd3);
    check_value("t5_flush_tag", 32'(alloc_tag), 32'd3);
    flush = 1'b1;
    flush_tag = IDX_W'(9);
    tick();
    flush = 1'b0;
    check_value("t5_idle_flush_count", 32'(count), 32'd3);
    check_value("t5_idle_flush_tag", 32'(alloc_tag), 32'd3);
    alloc_one(20, 1'b0);
    check_value("t5_realloc_tag", 32'(alloc_tag), 32'd4);
    alloc_one(21, 1'b0);
    check_value("t5_realloc_count", 32'(count), 32'd5);
    for (int k = 0; k < 4; k++) begin
      wb(k, DATA_W'(16'h0050 + k));
      tick();
      if (k > 0) expect_commit("t5_c", k - 1, (k - 1 < 3) ? (10 + k - 1) : 20, 16'h0050 + k - 1, 1);
    end
    wb_off();
    tick();
    expect_commit("t5_c3", 3, 20, 16'h0053, 1);
    tick();
    check_value("t5_tag4_not_done", 32'(commit_valid), 32'd0);
    check_value("t5_final_count", 32'(count), 32'd1);

`ifdef ROB_FWD_EN
    // 6b: forwarding lookup before and after writeback
    do_reset();
    alloc_one(1, 1'b0);
    alloc_one(2, 1'b0);
    lookup_tag_a = IDX_W'(1);
    lookup_tag_b = IDX_W'(0);
    #1;
    check_value("t6_fwd_ready_pre", 32'(lookup_ready_a), 32'd0);
    wb(1, 16'hBEEF); tick(); wb_off();
    check_value("t6_fwd_ready_a", 32'(lookup_ready_a), 32'd1);
    check_value("t6_fwd_data_a", 32'(lookup_data_a), 32'h0000BEEF);
    check_value("t6_fwd_ready_b", 32'(lookup_ready_b), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
